// File: rtl/riscv_fetch_queue.sv
// Instruction fetch queue: issues word-aligned fetches, buffers in-order responses with their PCs,
// and flushes on redirect while discarding responses to requests issued before the redirect.
module riscv_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data,
  output logic            rsp_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  // Stale requests can pile up across several redirects, so discard gets extra headroom.
  localparam int unsigned DiscW = CntW + 3;
  localparam logic [XLEN-1:0] ResetPcAligned = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  outstanding_q, outstanding_d;
  logic [DiscW-1:0] discard_q, discard_d;
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic             rsp_err_q, rsp_err_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];

  logic [CntW:0]   occupancy;
  logic            req_hs, pop, push;
  logic            rsp_stale, rsp_accept, rsp_spurious;
  logic [XLEN-1:0] redirect_pc_aligned;
  logic            unused_bits;

  assign unused_bits         = ^redirect_pc[1:0];
  assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Count plus outstanding never exceeds DEPTH, so every accepted request owns a slot.
  assign occupancy      = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && !redirect && (occupancy < (CntW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign inst_valid = !reset && !redirect && (count_q != '0);
  assign inst_pc    = pc_mem[head_q];
  assign inst_data  = data_mem[head_q];
  assign pop        = inst_valid && inst_ready;
  assign rsp_err    = rsp_err_q;

  assign rsp_stale    = imem_rsp_valid && (discard_q != '0);
  assign rsp_accept   = imem_rsp_valid && (discard_q == '0) && (outstanding_q != '0);
  assign rsp_spurious = imem_rsp_valid && (discard_q == '0) && (outstanding_q == '0);
  assign push         = rsp_accept && !redirect && !reset;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    head_d        = head_q;
    tail_d        = tail_q;
    rsp_err_d     = rsp_err_q || rsp_spurious;
    if (redirect) begin
      fetch_pc_d    = redirect_pc_aligned;
      rsp_pc_d      = redirect_pc_aligned;
      count_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      outstanding_d = '0;
      // Everything still in flight becomes stale; a response landing now is one of them.
      discard_d     = discard_q + DiscW'(outstanding_q) - DiscW'(rsp_stale || rsp_accept);
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_stale) discard_d = discard_q - DiscW'(1);
      if (rsp_accept) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        tail_d   = tail_q + PtrW'(1);
      end
      if (pop) head_d = head_q + PtrW'(1);
      outstanding_d = outstanding_q + CntW'(req_hs) - CntW'(rsp_accept);
      count_d       = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= ResetPcAligned;
      rsp_pc_q      <= ResetPcAligned;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]   <= rsp_pc_q;
      data_mem[tail_q] <= imem_rsp_data;
    end
  end

endmodule

// File: doc/riscv_fetch_queue.md
RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address/PC width; legal values 32 or 64; instruction data is fixed at 32 bits.
REQ-002 Parameter DEPTH, default 4, queue entries and maximum outstanding requests; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0, PC after reset; bits [1:0] treated as 00.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_req_addr  out  XLEN  word-aligned fetch address.
REQ-009 imem_rsp_valid  in  1  instruction word returned, in request order.
REQ-010 imem_rsp_data  in  32  returned instruction word.
REQ-011 redirect  in  1  flush and restart fetch at redirect_pc.
REQ-012 redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored.
REQ-013 inst_valid  out  1  queue head holds an instruction.
REQ-014 inst_ready  in  1  decode consumes head.
REQ-015 inst_pc  out  XLEN  PC of head instruction.
REQ-016 inst_data  out  32  head instruction word.
REQ-017 rsp_err  out  1  sticky: response seen with no request outstanding.

Function
REQ-018 Request handshake completes when imem_req_valid && imem_req_ready; response handshake is imem_rsp_valid alone (no backpressure).
REQ-019 fetch_pc register drives imem_req_addr; advances by 4 (mod 2^XLEN, wrap permitted) on each request handshake.
REQ-020 imem_req_valid = !redirect && (count + outstanding) < DEPTH; every accepted request therefore has a reserved queue slot.
REQ-021 imem_req_addr and imem_req_valid hold stable while valid && !ready.
REQ-022 outstanding counter (width clog2(DEPTH+1)): +1 on request handshake, -1 on response, net 0 when both in one cycle.
REQ-023 rsp_pc register tracks PC of the next expected response; advances by 4 per response accepted into the queue.
REQ-024 Accepted response writes {rsp_pc, imem_rsp_data} at tail; visible at head no earlier than the following cycle (no bypass).
REQ-025 discard counter: while nonzero, each response is dropped and decrements it; rsp_pc does not advance on dropped responses.
REQ-026 inst_valid = (count != 0) && !redirect; pop occurs on inst_valid && inst_ready.
REQ-027 Simultaneous push and pop in one cycle: count unchanged, both performed; pop from full queue with push permitted.
REQ-028 Redirect cycle: queue count cleared, fetch_pc and rsp_pc loaded with {redirect_pc[XLEN-1:2], 2'b00}, no request issued, no pop.
REQ-029 Redirect cycle: discard loaded with outstanding + discard minus any response arriving that same cycle; that response is dropped.
REQ-030 Back-to-back redirects: each applies REQ-028/029; last target wins.
REQ-031 Response with outstanding == 0 and discard == 0: dropped, rsp_err set until reset.
REQ-032 Queue storage is circular with head/tail pointers of clog2(DEPTH) bits wrapping at DEPTH.

Reset
REQ-033 Reset: fetch_pc = rsp_pc = RESET_PC aligned; count, outstanding, discard, head, tail = 0; rsp_err = 0.
REQ-034 During reset cycle: imem_req_valid = 0, inst_valid = 0; responses arriving are dropped without setting rsp_err.
REQ-035 Reset mid-operation abandons in-flight requests; memory-side draining is the system's responsibility.
REQ-036 Queue data storage requires no reset.

Verification
REQ-037 Stream: DEPTH=4, RESET_PC=0x100, ready=1, 1-cycle memory latency, inst_ready=1 -> inst_pc sequence 0x100,0x104,0x108... with matching data, no gaps after fill.
REQ-038 Backpressure: inst_ready=0 -> exactly 4 requests issued (0x100..0x10C), imem_req_valid then 0; raise inst_ready -> resumes at 0x110.
REQ-039 Redirect with 3 outstanding, redirect_pc=0x2003 -> next request addr 0x2000, 3 stale responses dropped, first inst_pc = 0x2000.
REQ-040 Redirect in same cycle as a response, 2 outstanding -> that response and 1 later dropped; discard reaches 0; no stale PC ever valid.
REQ-041 Wrap: XLEN=32, RESET_PC=0xFFFFFFF8 -> inst_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-042 Spurious response with none outstanding -> rsp_err=1, queue unchanged; reset clears rsp_err and returns fetch_pc to RESET_PC.
